// File: rtl/comm_line_sched_if.sv
// Transmit handshake between the line scheduler, the requesters and comm_transmitter.
// The scheduler takes the slave modport; requesters/transmitter take the master modport.
interface comm_line_sched_if;
    logic [1:0] req;
    logic       tx_busy;
    logic [1:0] grant;
    logic       tx_start;

    modport master (
        output req,
        output tx_busy,
        input  grant,
        input  tx_start
    );

    modport slave (
        input  req,
        input  tx_busy,
        output grant,
        output tx_start
    );
endinterface

// File: rtl/comm_line_sched.sv
// Half-duplex DOMHub line scheduler: arbitrates TX access and sequences RX/TX turnaround.
// Optional per-requester grant and abort statistics are built when COMM_SCHED_STATS_EN is defined.
module comm_line_sched #(
    parameter int unsigned TURN_TX_CYC    = 40,
    parameter int unsigned RX_BLANK_CYC   = 100,
    parameter int unsigned TX_TIMEOUT_CYC = 65535,
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             inclk,
    input  logic             reset_n,
    input  logic             rx_decoding,
    input  logic             clr_err,
    comm_line_sched_if.slave line,
    output logic             rx_enable,
    output logic             dac_blank,
    output logic             tx_timeout_err,
    output logic [2:0]       sched_state,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [7:0]       abort_cnt
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] TurnTxLast = CNT_W'(TURN_TX_CYC - 1);
    localparam logic [CNT_W-1:0] RxBlankLast = CNT_W'(RX_BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] TxTimeoutLast = CNT_W'(TX_TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRxBusy = 3'd1,
        StTurnTx = 3'd2,
        StTx     = 3'd3,
        StTurnRx = 3'd4
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         winner_q;
    logic [StarveW-1:0] starve_q;
    logic               busy_seen_q;

    logic [1:0]         arb_winner;
    logic [StarveW-1:0] arb_starve;
    logic               launch;
    logic               abort;

    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign launch      = (state_q == StTurnTx) && !rx_decoding && (cnt_q >= TurnTxLast);
    assign abort       = (state_q == StTurnTx) && rx_decoding;
    assign sched_state = state_q;

    // Fixed priority to req[0]; req[1] is forced through after STARVE_MAX consecutive losses.
    always_comb begin
        arb_winner = 2'b00;
        arb_starve = starve_q;
        case (line.req)
            2'b01: begin
                arb_winner = 2'b01;
                arb_starve = '0;
            end
            2'b10: begin
                arb_winner = 2'b10;
                arb_starve = '0;
            end
            2'b11: begin
                if (starve_q >= StarveW'(STARVE_MAX)) begin
                    arb_winner = 2'b10;
                    arb_starve = '0;
                end else begin
                    arb_winner = 2'b01;
                    arb_starve = starve_q + StarveW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            winner_q       <= '0;
            starve_q       <= '0;
            busy_seen_q    <= 1'b0;
            line.grant     <= 2'b00;
            line.tx_start  <= 1'b0;
            rx_enable      <= 1'b1;
            dac_blank      <= 1'b1;
            tx_timeout_err <= 1'b0;
        end else begin
            line.tx_start <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (clr_err) begin
                tx_timeout_err <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (rx_decoding) begin
                        state_q <= StRxBusy;
                        cnt_q   <= '0;
                    end else if (line.req != 2'b00) begin
                        state_q   <= StTurnTx;
                        cnt_q     <= '0;
                        winner_q  <= arb_winner;
                        starve_q  <= arb_starve;
                        rx_enable <= 1'b0;
                    end
                end
                StRxBusy: begin
                    cnt_q <= '0;
                    if (!rx_decoding) begin
                        state_q <= StIdle;
                    end
                end
                StTurnTx: begin
                    if (abort) begin
                        state_q   <= StRxBusy;
                        cnt_q     <= '0;
                        winner_q  <= '0;
                        rx_enable <= 1'b1;
                    end else if (launch) begin
                        state_q       <= StTx;
                        cnt_q         <= '0;
                        busy_seen_q   <= 1'b0;
                        line.tx_start <= 1'b1;
                        line.grant    <= winner_q;
                        dac_blank     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StTx: begin
                    if (line.tx_busy) begin
                        busy_seen_q <= 1'b1;
                    end
                    if (busy_seen_q && !line.tx_busy) begin
                        state_q    <= StTurnRx;
                        cnt_q      <= '0;
                        line.grant <= 2'b00;
                        dac_blank  <= 1'b1;
                    end else if (cnt_q >= TxTimeoutLast) begin
                        state_q        <= StTurnRx;
                        cnt_q          <= '0;
                        line.grant     <= 2'b00;
                        dac_blank      <= 1'b1;
                        tx_timeout_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StTurnRx: begin
                    if (cnt_q >= RxBlankLast) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        rx_enable <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cnt_q      <= '0;
                    line.grant <= 2'b00;
                    rx_enable  <= 1'b1;
                    dac_blank  <= 1'b1;
                end
            endcase
        end
    end

`ifdef COMM_SCHED_STATS_EN
    logic [15:0] gcnt0_q;
    logic [15:0] gcnt1_q;
    logic [7:0]  abort_q;

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            abort_q <= '0;
        end else if (clr_err) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            abort_q <= '0;
        end else begin
            if (launch && winner_q[0] && (gcnt0_q != 16'hffff)) begin
                gcnt0_q <= gcnt0_q + 16'd1;
            end
            if (launch && winner_q[1] && (gcnt1_q != 16'hffff)) begin
                gcnt1_q <= gcnt1_q + 16'd1;
            end
            if (abort && (abort_q != 8'hff)) begin
                abort_q <= abort_q + 8'd1;
            end
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
    assign abort_cnt  = abort_q;
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
    assign abort_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_comm_line_sched.sv
// Directed self-checking bench for comm_line_sched (default parameters).
module tb_comm_line_sched;

`ifdef COMM_SCHED_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic        inclk;
    logic        reset_n;
    logic        rx_decoding;
    logic        clr_err;
    logic        rx_enable;
    logic        dac_blank;
    logic        tx_timeout_err;
    logic [2:0]  sched_state;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [7:0]  abort_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    comm_line_sched_if bus ();

    comm_line_sched dut (
        .inclk          (inclk),
        .reset_n        (reset_n),
        .rx_decoding    (rx_decoding),
        .clr_err        (clr_err),
        .line           (bus),
        .rx_enable      (rx_enable),
        .dac_blank      (dac_blank),
        .tx_timeout_err (tx_timeout_err),
        .sched_state    (sched_state),
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .abort_cnt      (abort_cnt)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic wait_start(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.tx_start && n < max_cyc);
        check("tx_start_seen", 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (sched_state != 3'd0 && n < max_cyc) begin
            tick();
            n++;
        end
        check("reach_idle", 32'(sched_state), 32'd0);
    endtask

    // Short transmitter burst right after tx_start, then check the grant drops.
    task automatic finish_frame();
        bus.tx_busy = 1'b1;
        repeat (3) tick();
        bus.tx_busy = 1'b0;
        tick();
        check("frame_end_grant", 32'(bus.grant), 32'd0);
        check("frame_end_state", 32'(sched_state), 32'd4);
    endtask

    task automatic check_stats(input string tag, input int g0, input int g1, input int ab);
        check({tag, "_gcnt0"}, 32'(grant_cnt0), StatsOn ? 32'(g0) : 32'd0);
        check({tag, "_gcnt1"}, 32'(grant_cnt1), StatsOn ? 32'(g1) : 32'd0);
        check({tag, "_abort"}, 32'(abort_cnt), StatsOn ? 32'(ab) : 32'd0);
    endtask

    logic [1:0] exp_seq [6];

    initial begin
        int n;
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        reset_n     = 1'b0;
        rx_decoding = 1'b0;
        clr_err     = 1'b0;
        bus.req     = 2'b00;
        bus.tx_busy = 1'b0;
        repeat (3) tick();

        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_rx_enable", 32'(rx_enable), 32'd1);
        check("rst_dac_blank", 32'(dac_blank), 32'd1);
        check("rst_err", 32'(tx_timeout_err), 32'd0);
        check("rst_state", 32'(sched_state), 32'd0);
        check_stats("rst", 0, 0, 0);
        reset_n = 1'b1;
        tick();
        check("idle_after_release", 32'(sched_state), 32'd0);

        // Single response frame with a 200-cycle transmission.
        bus.req = 2'b01;
        wait_start(100, n);
        check("t1_latency", 32'(n), 32'd41);
        check("t1_grant", 32'(bus.grant), 32'd1);
        check("t1_dac_blank", 32'(dac_blank), 32'd0);
        check("t1_rx_enable", 32'(rx_enable), 32'd0);
        check("t1_state", 32'(sched_state), 32'd3);
        bus.req     = 2'b00;
        bus.tx_busy = 1'b1;
        tick();
        check("t1_start_one_cycle", 32'(bus.tx_start), 32'd0);
        repeat (199) tick();
        check("t1_grant_held", 32'(bus.grant), 32'd1);
        bus.tx_busy = 1'b0;
        tick();
        check("t1_grant_drop", 32'(bus.grant), 32'd0);
        check("t1_turn_rx", 32'(sched_state), 32'd4);
        check("t1_blank_rx", 32'(rx_enable), 32'd0);
        check("t1_dac_back", 32'(dac_blank), 32'd1);
        n = 0;
        while (!rx_enable && n < 300) begin
            tick();
            n++;
        end
        check("t1_rx_blank_len", 32'(n), 32'd100);
        check("t1_back_idle", 32'(sched_state), 32'd0);

        // Receiver activity during turnaround aborts the launch.
        bus.req = 2'b01;
        tick();
        check("t2_turn_tx", 32'(sched_state), 32'd2);
        repeat (19) tick();
        rx_decoding = 1'b1;
        tick();
        check("t2_abort_state", 32'(sched_state), 32'd1);
        check("t2_abort_start", 32'(bus.tx_start), 32'd0);
        check("t2_abort_grant", 32'(bus.grant), 32'd0);
        check("t2_abort_rx_en", 32'(rx_enable), 32'd1);
        repeat (3) tick();
        check("t2_rx_busy_hold", 32'(sched_state), 32'd1);
        rx_decoding = 1'b0;
        tick();
        check("t2_idle", 32'(sched_state), 32'd0);
        wait_start(100, n);
        check("t2_rearb_latency", 32'(n), 32'd41);
        check("t2_grant", 32'(bus.grant), 32'd1);
        bus.req = 2'b00;
        finish_frame();
        wait_idle(200);

        // One more response frame, then the statistics snapshot.
        bus.req = 2'b01;
        wait_start(100, n);
        bus.req = 2'b00;
        finish_frame();
        wait_idle(200);
        check_stats("t3", 3, 0, 1);

        // Both requests held: auxiliary gets through after four response wins.
        bus.req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_start(300, n);
            check($sformatf("t4_grant_%0d", k), 32'(bus.grant), 32'(exp_seq[k]));
            if (k == 5) bus.req = 2'b00;
            finish_frame();
        end
        wait_idle(200);
        check_stats("t4", 8, 1, 1);

        // tx_busy never rises: forced abort; clr_err coincident with the timeout loses.
        bus.req = 2'b01;
        wait_start(100, n);
        bus.req = 2'b00;
        repeat (65534) tick();
        check("t5_still_tx", 32'(sched_state), 32'd3);
        check("t5_no_err_yet", 32'(tx_timeout_err), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_timeout_state", 32'(sched_state), 32'd4);
        check("t5_err_set_wins", 32'(tx_timeout_err), 32'd1);
        check("t5_grant", 32'(bus.grant), 32'd0);
        check("t5_dac_blank", 32'(dac_blank), 32'd1);
        tick();
        check("t5_err_sticky", 32'(tx_timeout_err), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_err_cleared", 32'(tx_timeout_err), 32'd0);
        check_stats("t5", 0, 0, 0);
        wait_idle(200);

        // Asynchronous reset in the middle of a transmission.
        bus.req = 2'b01;
        wait_start(100, n);
        bus.req     = 2'b00;
        bus.tx_busy = 1'b1;
        repeat (5) tick();
        check("t6_in_tx", 32'(sched_state), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_grant", 32'(bus.grant), 32'd0);
        check("t6_rst_dac", 32'(dac_blank), 32'd1);
        check("t6_rst_rx_en", 32'(rx_enable), 32'd1);
        check("t6_rst_state", 32'(sched_state), 32'd0);
        bus.tx_busy = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_state_after", 32'(sched_state), 32'd0);
        check("t6_rx_en_after", 32'(rx_enable), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
